cmd_parser: RTL

Byte-level command decoder between `uart_rx` and the glitch engine. Consumes received UART bytes and decodes the host protocol: a `0x00`-prefixed command, or a length-prefixed passthrough frame. Holds the glitch configuration registers (width, pulse count, 32-bit delay), issues reset and arm strobes, and forwards passthrough payload bytes to the target-side transmitter.

---
 rtl/glitcher_pkg.sv | 39 +++
 rtl/cmd_parser_pulse_stretch.sv | 37 +++
 rtl/cmd_parser.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/glitcher_pkg.sv
// Shared types and command bytes for the host-side glitcher protocol.
package glitcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_ARG,
    ST_PASS
  } state_t;

  typedef enum logic [2:0] {
    SEL_WIDTH,
    SEL_PULSES,
    SEL_DELAY0,
    SEL_DELAY1,
    SEL_DELAY2,
    SEL_DELAY3
  } sel_t;

  localparam logic [7:0] CMD_PREFIX = 8'h00;
  localparam logic [7:0] CMD_RST    = 8'hFF;
  localparam logic [7:0] CMD_BRST   = 8'hFE;
  localparam logic [7:0] CMD_WIDTH  = 8'h10;
  localparam logic [7:0] CMD_PULSES = 8'h11;
  localparam logic [7:0] CMD_DELAY0 = 8'h20;
  localparam logic [7:0] CMD_DELAY1 = 8'h21;
  localparam logic [7:0] CMD_DELAY2 = 8'h22;
  localparam logic [7:0] CMD_DELAY3 = 8'h23;

  // Replace one byte lane of the 32-bit delay register.
  function automatic logic [31:0] set_lane(input logic [31:0] d, input logic [1:0] lane,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = d;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/cmd_parser_pulse_stretch.sv
// Stretches a start strobe into a BRST_CYCLES-long board reset, with arm on its last cycle.
module pulse_stretch
  import glitcher_pkg::*;
#(
  parameter int BRST_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic board_rst,
  output logic arm
);

  localparam int CW = $clog2(BRST_CYCLES + 1);

  // cnt holds the number of high cycles still to come after the current one.
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= '0;
      board_rst <= 1'b0;
      arm       <= 1'b0;
    end else if (start) begin
      cnt       <= CW'(BRST_CYCLES - 1);
      board_rst <= 1'b1;
      arm       <= (BRST_CYCLES == 1);
    end else if (board_rst && cnt != '0) begin
      cnt <= cnt - CW'(1);
      arm <= (cnt == CW'(1));
    end else begin
      board_rst <= 1'b0;
      arm       <= 1'b0;
    end
  end

endmodule

// File: rtl/cmd_parser.sv
// Host protocol decoder: 0x00-prefixed commands and length-prefixed passthrough frames.
module cmd_parser
  import glitcher_pkg::*;
#(
  parameter logic [7:0]  WIDTH_RST   = 8'd1,
  parameter logic [7:0]  PULSES_RST  = 8'd0,
  parameter logic [31:0] DELAY_RST   = 32'd0,
  parameter int          BRST_CYCLES = 16,
  parameter int          TIMEOUT     = 120000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  width,
  output logic [7:0]  pulses,
  output logic [31:0] delay,
  output logic        glitch_rst,
  output logic        board_rst,
  output logic        arm,
  output logic [7:0]  pt_data,
  output logic        pt_valid,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_n;
  sel_t          sel, sel_n;
  logic [7:0]    remain, remain_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [7:0]    rx_q;
  logic          rx_vq;
  logic [7:0]    width_n, pulses_n, pt_data_n;
  logic [31:0]   delay_n;
  logic          glitch_rst_n, pt_valid_n, err_n, brst_start;

  // Incoming bytes are registered once, then decoded into registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_q       <= '0;
      rx_vq      <= 1'b0;
      state      <= ST_IDLE;
      sel        <= SEL_WIDTH;
      remain     <= '0;
      tmo        <= '0;
      width      <= WIDTH_RST;
      pulses     <= PULSES_RST;
      delay      <= DELAY_RST;
      glitch_rst <= 1'b0;
      pt_data    <= '0;
      pt_valid   <= 1'b0;
      err        <= 1'b0;
    end else begin
      rx_q       <= rx_data;
      rx_vq      <= rx_valid;
      state      <= state_n;
      sel        <= sel_n;
      remain     <= remain_n;
      tmo        <= tmo_n;
      width      <= width_n;
      pulses     <= pulses_n;
      delay      <= delay_n;
      glitch_rst <= glitch_rst_n;
      pt_data    <= pt_data_n;
      pt_valid   <= pt_valid_n;
      err        <= err_n;
    end
  end

  always_comb begin
    state_n      = state;
    sel_n        = sel;
    remain_n     = remain;
    tmo_n        = tmo;
    width_n      = width;
    pulses_n     = pulses;
    delay_n      = delay;
    pt_data_n    = pt_data;
    glitch_rst_n = 1'b0;
    pt_valid_n   = 1'b0;
    err_n        = 1'b0;
    brst_start   = 1'b0;
    if (rx_vq) begin
      tmo_n = '0;
      case (state)
        ST_IDLE: begin
          if (rx_q == CMD_PREFIX) begin
            state_n = ST_CMD;
          end else begin
            state_n  = ST_PASS;
            remain_n = rx_q;
          end
        end
        ST_CMD: begin
          state_n = ST_IDLE;
          case (rx_q)
            CMD_RST: begin
              width_n      = WIDTH_RST;
              pulses_n     = PULSES_RST;
              delay_n      = DELAY_RST;
              glitch_rst_n = 1'b1;
            end
            CMD_BRST:   brst_start = 1'b1;
            CMD_WIDTH:  begin sel_n = SEL_WIDTH;  state_n = ST_ARG; end
            CMD_PULSES: begin sel_n = SEL_PULSES; state_n = ST_ARG; end
            CMD_DELAY0: begin sel_n = SEL_DELAY0; state_n = ST_ARG; end
            CMD_DELAY1: begin sel_n = SEL_DELAY1; state_n = ST_ARG; end
            CMD_DELAY2: begin sel_n = SEL_DELAY2; state_n = ST_ARG; end
            CMD_DELAY3: begin sel_n = SEL_DELAY3; state_n = ST_ARG; end
            default:    err_n = 1'b1;
          endcase
        end
        ST_ARG: begin
          state_n = ST_IDLE;
          case (sel)
            SEL_WIDTH:  width_n  = rx_q;
            SEL_PULSES: pulses_n = rx_q;
            SEL_DELAY0: delay_n  = set_lane(delay, 2'd0, rx_q);
            SEL_DELAY1: delay_n  = set_lane(delay, 2'd1, rx_q);
            SEL_DELAY2: delay_n  = set_lane(delay, 2'd2, rx_q);
            SEL_DELAY3: delay_n  = set_lane(delay, 2'd3, rx_q);
            default:    width_n  = width;
          endcase
        end
        ST_PASS: begin
          pt_valid_n = 1'b1;
          pt_data_n  = rx_q;
          remain_n   = remain - 8'd1;
          if (remain == 8'd1) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end else if (state != ST_IDLE) begin
      // A byte landing on the final cycle takes the branch above instead.
      if (tmo == TMO_LAST) begin
        state_n  = ST_IDLE;
        err_n    = 1'b1;
        tmo_n    = '0;
        remain_n = '0;
      end else begin
        tmo_n = tmo + TW'(1);
      end
    end
  end

  pulse_stretch #(
    .BRST_CYCLES(BRST_CYCLES)
  ) u_pulse_stretch (
    .clk      (clk),
    .rst      (rst),
    .start    (brst_start),
    .board_rst(board_rst),
    .arm      (arm)
  );

endmodule
